hex_cmd_parser: RTL and testbench

- Upstream command front-end for the UART hex calculator.
- Consumes the byte stream from the UART receiver and parses an ASCII command of the form `AAAA*BBBB<CR>` into two 16-bit operands.
- Drives the Booth multiplier's operand inputs and one-cycle `start` pulse, holds the operands stable for the whole calculation, and flags when the product is ready.

---
 rtl/hex_cmd_parser.sv | 190 +++++++++++++++++++
 tb/tb_hex_cmd_parser.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_cmd_parser.sv
// ASCII "AAAA*BBBB<CR>" command parser driving a Booth multiplier's operands and start/done.
// Optional byte echo on tx_* is built only when HEX_PARSER_ECHO_EN is defined.
module hex_cmd_parser #(
  parameter int CALC_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] M,
  output logic [15:0] Q,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPA   = 3'd1;
  localparam logic [2:0] S_OPB   = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam int            CW       = $clog2(CALC_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CALC_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_STAR = 8'h2A;

  logic [2:0]    state_q, state_d;
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   m_q, m_d;
  logic [15:0]   q_q, q_d;
  logic [2:0]    dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic       is_hex;
  logic [3:0] nib;

  // Letters A-F and a-f share the low nibble 1..6, so +9 gives 10..15.
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      nib = rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_hex) begin
            state_d = S_OPA;
            acc_d   = {12'h000, nib};
            dig_d   = 3'd1;
          end else if (rx_data != CH_CR && rx_data != CH_SP) begin
            err_d   = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_OPA, S_OPB: begin
        if (rx_valid && rx_data != CH_SP) begin
          if (is_hex && dig_q != 3'd4) begin
            acc_d = {acc_q[11:0], nib};
            dig_d = dig_q + 3'd1;
          end else if (state_q == S_OPA && rx_data == CH_STAR) begin
            a_d     = acc_q;
            acc_d   = 16'h0000;
            dig_d   = 3'd0;
            state_d = S_OPB;
          end else if (state_q == S_OPB && rx_data == CH_CR && dig_q != 3'd0) begin
            m_d     = a_q;
            q_d     = acc_q;
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_CALC;
          end else begin
            // A malformed CR already terminates the line, so there is nothing left to flush.
            err_d   = 1'b1;
            state_d = (rx_data == CH_CR) ? S_IDLE : S_FLUSH;
          end
        end
      end
      S_CALC: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CNT_ONE;
          done_d = (cnt_q == CNT_ONE);
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (rx_valid && rx_data == CH_CR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      a_q     <= 16'h0000;
      m_q     <= 16'h0000;
      q_q     <= 16'h0000;
      dig_q   <= 3'd0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign M     = m_q;
  assign Q     = q_q;
  assign start = start_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

`ifdef HEX_PARSER_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  // Every byte seen outside CALC is echoed, including ones that trigger or follow an error.
  always_comb begin
    tx_valid_d = rx_valid && (state_q != S_CALC);
    tx_data_d  = tx_valid_d ? rx_data : tx_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
`else
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Bench for hex_cmd_parser: line-level command model with per-cycle compare plus directed literal checks.
// Echo expectations follow HEX_PARSER_ECHO_EN when it is defined for the build.
module tb_hex_cmd_parser;

  localparam int CALC = 16;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] SP = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] M, Q;
  logic        start, busy, done, err;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b0;
  int err_seen = 0, start_seen = 0, done_seen = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  hex_cmd_parser #(.CALC_CYCLES(CALC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .M(M), .Q(Q), .start(start), .busy(busy), .done(done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- command-line model ----------------
  logic [15:0] exp_m = 16'h0, exp_q = 16'h0;
  logic        exp_start = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_txv = 1'b0;
  logic [7:0]  exp_txd = 8'h00;
  logic [7:0]  line_q[$];
  bit          flushing = 1'b0;
  bit          calc_active = 1'b0;
  int          calc_n = 0;
  int          cyc = 0;

  function automatic bit is_hex_ch(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hex_val(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  // Is the buffered line a legal command (complete=1) or a legal prefix of one (complete=0)?
  function automatic bit line_ok(input bit complete);
    int stars = 0;
    int na = 0;
    int nb = 0;
    foreach (line_q[i]) begin
      if (line_q[i] == 8'h2A) stars++;
      else if (is_hex_ch(line_q[i])) begin
        if (stars == 0) na++;
        else nb++;
      end else return 1'b0;
    end
    if (stars > 1 || na > 4 || nb > 4) return 1'b0;
    if (stars == 1 && na == 0) return 1'b0;
    if (complete) return (stars == 1) && (nb >= 1);
    return 1'b1;
  endfunction

  function automatic logic [15:0] operand(input bit second);
    logic [15:0] v = 16'h0;
    bit past = 1'b0;
    foreach (line_q[i]) begin
      if (line_q[i] == 8'h2A) past = 1'b1;
      else if (past == second) v = v * 16 + 16'(hex_val(line_q[i]));
    end
    return v;
  endfunction

  initial begin
    int e;
    int nxt;
    bit in_calc;
    logic [7:0] b;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_m = 16'h0; exp_q = 16'h0; exp_start = 0; exp_busy = 0; exp_done = 0;
        exp_err = 0; exp_txv = 0; exp_txd = 8'h00;
        line_q.delete(); flushing = 0; calc_active = 0;
      end else begin
        e = cyc;
        in_calc = calc_active && (e >= calc_n + 1) && (e <= calc_n + 1 + CALC);
        exp_start = 0; exp_err = 0; exp_txv = 0;
        if (rx_valid && !in_calc) begin
          b = rx_data;
`ifdef HEX_PARSER_ECHO_EN
          exp_txv = 1'b1;
          exp_txd = b;
`endif
          if (flushing) begin
            if (b == CR) flushing = 0;
          end else if (b == CR) begin
            if (line_q.size() != 0) begin
              if (line_ok(1'b1)) begin
                exp_m = operand(1'b0); exp_q = operand(1'b1);
                exp_start = 1; calc_active = 1; calc_n = e;
              end else exp_err = 1;
              line_q.delete();
            end
          end else if (b != SP) begin
            line_q.push_back(b);
            if (!line_ok(1'b0)) begin
              exp_err = 1; flushing = 1; line_q.delete();
            end
          end
        end
        nxt = e + 1;
        exp_busy = calc_active && (nxt >= calc_n + 1) && (nxt <= calc_n + 1 + CALC);
        exp_done = calc_active && (nxt == calc_n + 1 + CALC);
        if (calc_active && nxt > calc_n + 1 + CALC) calc_active = 0;
        cyc = nxt;
      end
    end
  end

  // ---------------- per-cycle compare and pulse monitors ----------------
  initial forever begin
    @(negedge clk);
    if (running) begin
      chk("M", M, exp_m);
      chk("Q", Q, exp_q);
      chk("start", start, exp_start);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("tx_valid", tx_valid, exp_txv);
`ifdef HEX_PARSER_ECHO_EN
      if (exp_txv || rst) chk("tx_data", tx_data, exp_txd);
`else
      chk("tx_data", tx_data, 8'h00);
`endif
      if (!rst) begin
        if (err) err_seen++;
        if (start) start_seen++;
        if (done) done_seen++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i]);
  endtask

  task automatic cmd(input string s);
    send_str(s);
    drive(CR);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_counts();
    err_seen = 0; start_seen = 0; done_seen = 0;
  endtask

  // Called in the cycle after the CR; lat ends as k where done is seen in cycle N+k.
  task automatic wait_done(output int lat);
    lat = 1;
    busy_cycles = 0;
    while (lat <= CALC + 10) begin
      if (busy) busy_cycles++;
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    if (lat > CALC + 10) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    #3 rst = 1'b1;
    running = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_M", M, 16'h0000);
    chk("rst_Q", Q, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(1);

    // 12*34 with start/busy/done timing and first-byte echo
    clear_counts();
    drive(8'h31);
`ifdef HEX_PARSER_ECHO_EN
    chk("t1_echo_v", tx_valid, 1'b1);
    chk("t1_echo_d", tx_data, 8'h31);
`else
    chk("t1_echo_v", tx_valid, 1'b0);
`endif
    cmd("2*34");
    chk("t1_start", start, 1'b1);
    chk("t1_busy", busy, 1'b1);
    wait_done(lat);
    chk("t1_latency", lat, CALC + 1);
    chk("t1_busy_cycles", busy_cycles, CALC + 1);
    chk("t1_M", M, 16'h0012);
    chk("t1_Q", Q, 16'h0034);
    chk("t1_busy_after", busy, 1'b0);

    // mixed case and spaces
    clear_counts();
    cmd("fFfF * 0002");
    wait_done(lat);
    chk("t2_M", M, 16'hFFFF);
    chk("t2_Q", Q, 16'h0002);
    chk("t2_err_cnt", err_seen, 0);
    chk("t2_start_cnt", start_seen, 1);

    // five-digit operand: error one cycle after '5', rest flushed
    clear_counts();
    send_str("12345");
    chk("t3_err_timing", err, 1'b1);
    cmd("*1");
    idle(2);
    chk("t3_err_cnt", err_seen, 1);
    chk("t3_start_cnt", start_seen, 0);
    chk("t3_M_kept", M, 16'hFFFF);
    chk("t3_Q_kept", Q, 16'h0002);
    cmd("1*1");
    wait_done(lat);
    chk("t3_M", M, 16'h0001);
    chk("t3_Q", Q, 16'h0001);

    // malformed commands, back to back
    clear_counts();
    cmd("*5");
    cmd("5*");
    cmd("5+3");
    idle(3);
    chk("t4_err_cnt", err_seen, 3);
    chk("t4_start_cnt", start_seen, 0);
    chk("t4_M_kept", M, 16'h0001);

    // command sent during busy is dropped
    clear_counts();
    cmd("2*3");
    cmd("9*9");
    wait_done(lat);
    idle(3);
    chk("t5_M", M, 16'h0002);
    chk("t5_Q", Q, 16'h0003);
    chk("t5_start_cnt", start_seen, 1);
    chk("t5_err_cnt", err_seen, 0);

    // reset in cycle 5 of CALC, then a clean command
    clear_counts();
    cmd("7*8");
    idle(4);
    rst = 1'b1;
    #1;
    chk("t6_rst_M", M, 16'h0000);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_start", start, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    idle(CALC + 8);
    chk("t6_no_done", done_seen, 0);
    clear_counts();
    cmd("7*8");
    chk("t6_start", start, 1'b1);
    wait_done(lat);
    chk("t6_latency", lat, CALC + 1);
    chk("t6_M", M, 16'h0007);
    chk("t6_Q", Q, 16'h0008);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
